// File: rtl/axis_adc_avg_decim.sv
// axis_adc_avg_decim: boxcar-averages 2**LOG2_AVG AXIS samples into one output, tlast every FRAME_LEN outputs.
// Define AXIS_ADC_AVG_ROUND_EN for round-half-up instead of truncation.
module axis_adc_avg_decim #(
  parameter int DATA_W    = 16,
  parameter int LOG2_AVG  = 3,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       frame_count
);
  localparam int AW = DATA_W + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LOG2_AVG) - 1);
  localparam logic [15:0] IDX_MAX = 16'(FRAME_LEN - 1);
`ifdef AXIS_ADC_AVG_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((1 << LOG2_AVG) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif
  typedef enum logic {ACCUM, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d, frames_q, frames_d;
  logic [DATA_W-1:0] data_q, data_d, avg;
  logic valid_q, valid_d, last_q, last_d, in_hs, out_hs, blk_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      frames_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end
  // The full block sum always fits AW bits, even with the rounding bias added.
  always_comb begin
    in_hs    = (state_q == ACCUM) && s_axis_tvalid;
    out_hs   = valid_q && m_axis_tready;
    sum      = acc_q + AW'(s_axis_tdata) + RND;
    avg      = DATA_W'(sum >> LOG2_AVG);
    blk_done = in_hs && (cnt_q == CNT_MAX);
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (in_hs) begin
      acc_d = blk_done ? '0 : acc_q + AW'(s_axis_tdata);
      cnt_d = blk_done ? '0 : cnt_q + 1'b1;
    end
    if (blk_done) begin
      data_d  = avg;
      valid_d = 1'b1;
      last_d  = (idx_q == IDX_MAX);
      state_d = OUTPUT;
    end
    if (out_hs) begin
      valid_d  = 1'b0;
      last_d   = 1'b0;
      state_d  = ACCUM;
      idx_d    = last_q ? '0 : idx_q + 16'd1;
      frames_d = frames_q + 16'(last_q);
    end
  end
  assign s_axis_tready = (state_q == ACCUM);
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign frame_count   = frames_q;
endmodule

// File: tb/tb_axis_adc_avg_decim.sv
// tb_axis_adc_avg_decim: scoreboard bench, 4-sample average, 4-output frames.
module tb_axis_adc_avg_decim;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;
  logic [15:0] frame_count;
  int total = 0;
  int bad = 0;
  int mode = 0;
  logic [16:0] exp_q[$];
  logic [17:0] acc_m = '0;
  int cnt_m = 0;
  int outk = 0;
  int frames_m = 0;

  axis_adc_avg_decim #(.DATA_W(16), .LOG2_AVG(2), .FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic fail(string n);
    total++;
    bad++;
    $display("FAIL %s: event missing", n);
  endtask

  task automatic model(logic [15:0] d);
    logic tl;
    acc_m += 18'(d);
    cnt_m++;
    if (cnt_m == 4) begin
`ifdef AXIS_ADC_AVG_ROUND_EN
      acc_m += 18'd2;
`endif
      tl = (outk == 3);
      exp_q.push_back({tl, acc_m[17:2]});
      outk = tl ? 0 : outk + 1;
      if (tl) frames_m++;
      acc_m = '0;
      cnt_m = 0;
    end
  endtask

  task automatic send(logic [15:0] d, int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      fail("send_timeout");
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    model(d);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc_m = '0;
    cnt_m = 0;
    outk = 0;
    frames_m = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", m_axis_tvalid, 0);
  endtask

  task automatic chk_reset();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_frames", frame_count, 0);
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks hold stability under stall.
  logic stall = 1'b0;
  logic [15:0] hold_d;
  logic hold_l;
  logic [16:0] e;
  always @(negedge clk) begin
    if (reset) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", m_axis_tdata, hold_d);
        chk("hold_last", m_axis_tlast, hold_l);
      end
      stall = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) fail("unexpected_out");
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e[15:0]);
          chk("out_last", m_axis_tlast, e[16]);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset();
    // Test 1: 1,2,3,4 -> 2 (3 when rounding), valid one cycle after the last accept
    send(16'd1, 0);
    send(16'd2, 0);
    send(16'd3, 0);
    send(16'd4, 0);
    @(negedge clk);
    chk("t1_latency", m_axis_tvalid, 1);
`ifdef AXIS_ADC_AVG_ROUND_EN
    chk("t1_value", m_axis_tdata, 16'h0003);
`else
    chk("t1_value", m_axis_tdata, 16'h0002);
`endif
    drain();
    // Test 2: full-scale input must not overflow
    for (int i = 0; i < 8; i++) send(16'hFFFF, 0);
    drain();
    // Test 3: stalled output holds and blocks input
    mode = 2;
    send(16'd10, 0);
    send(16'd20, 0);
    send(16'd30, 0);
    send(16'd40, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid", m_axis_tvalid, 1);
      chk("t3_data", m_axis_tdata, 16'd25);
      chk("t3_sready", s_axis_tready, 0);
    end
    mode = 0;
    drain();
    for (int i = 0; i < 4; i++) send(16'd7, 0);
    drain();
    // Test 4: frame boundaries
    do_reset();
    for (int g = 0; g < 9; g++)
      for (int i = 0; i < 4; i++) send(16'(100 + g), 0);
    drain();
    chk("t4_frames", frame_count, 2);
    // Test 5: reset mid-block discards the partial sum
    for (int i = 0; i < 3; i++) send(16'hAAAA, 0);
    do_reset();
    chk_reset();
    for (int i = 0; i < 4; i++) send(16'h0010, 0);
    @(negedge clk);
    chk("t5_value", m_axis_tdata, 16'h0010);
    drain();
    // Test 6: random data, gaps and backpressure
    mode = 1;
    for (int i = 0; i < 1000; i++) send(16'($urandom_range(0, 65535)), $urandom_range(0, 2));
    drain();
    chk("t6_frames", frame_count, 32'(frames_m[15:0]));
    mode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
